// File: rtl/fp_core_arbiter.sv
// Round-robin arbiter that shares one fp_core between two requesters.
// Latches the winner's operands, drives the core select, and returns the result with a one-cycle ack.
module fp_core_arbiter #(
  parameter int unsigned W   = 256,
  parameter int unsigned TMO = 1023,
  parameter int unsigned TW  = 10
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         req0,
  input  logic         op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic         op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] rsp,
  output logic         err,
  output logic         busy,
  output logic [2:0]   core_sel,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  input  logic [W-1:0] core_mm,
  input  logic         core_end,
  input  logic [W-1:0] core_as
);

  typedef enum logic [1:0] {IDLE, MM_WAIT, AS_CAP, DRAIN} state_t;

  localparam logic [2:0] SEL_MM   = 3'b100;
  localparam logic [2:0] SEL_AS   = 3'b010;
  localparam logic [2:0] SEL_IDLE = 3'b000;

  state_t         state, state_nx;
  logic           owner, rr_ptr;
  logic [TW-1:0]  cnt;

  logic           any_req, winner, win_op;
  logic           mm_done, mm_tmo;

  logic           owner_d, rr_d, ack_d, err_d;
  logic [TW-1:0]  cnt_d;
  logic [W-1:0]   rsp_d, a_d, b_d;
  logic [2:0]     sel_d;

  // Ties go to the rr pointer; a lone requester always wins.
  assign any_req = req0 | req1;
  assign winner  = (req0 && req1) ? rr_ptr : req1;
  assign win_op  = winner ? op1 : op0;

  // end_mm is stale on the first MM_WAIT cycle (cnt == 0); it beats a timeout on the same cycle.
  assign mm_done = (cnt != '0) && core_end;
  assign mm_tmo  = !mm_done && (cnt == TW'(TMO));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = win_op ? MM_WAIT : AS_CAP;
      AS_CAP:  state_nx = IDLE;
      MM_WAIT: if (mm_done || mm_tmo) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner;
    rr_d    = rr_ptr;
    cnt_d   = cnt;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rsp_d   = rsp;
    sel_d   = core_sel;
    a_d     = core_a;
    b_d     = core_b;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          rr_d    = ~winner;
          a_d     = winner ? a1 : a0;
          b_d     = winner ? b1 : b0;
          sel_d   = win_op ? SEL_MM : SEL_AS;
        end
      end
      AS_CAP: begin
        rsp_d = core_as;
        ack_d = 1'b1;
        sel_d = SEL_IDLE;
      end
      MM_WAIT: begin
        if (mm_done) begin
          rsp_d = core_mm;
          ack_d = 1'b1;
          sel_d = SEL_IDLE;
        end else if (mm_tmo) begin
          rsp_d = '0;
          err_d = 1'b1;
          ack_d = 1'b1;
          sel_d = SEL_IDLE;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      DRAIN: begin
        cnt_d = '0;
        sel_d = SEL_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      cnt      <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      rsp      <= '0;
      core_sel <= SEL_IDLE;
      core_a   <= '0;
      core_b   <= '0;
    end else begin
      owner    <= owner_d;
      rr_ptr   <= rr_d;
      cnt      <= cnt_d;
      ack0     <= ack_d && !owner;
      ack1     <= ack_d && owner;
      err      <= err_d;
      rsp      <= rsp_d;
      core_sel <= sel_d;
      core_a   <= a_d;
      core_b   <= b_d;
    end
  end

endmodule

// File: tb/tb_fp_core_arbiter.sv
// Bench for fp_core_arbiter: behavioural fp_core (end_mm N cycles after select, mm = a^b, as = a-b)
// and a transaction-level model of grant order, results and latency.
module tb_fp_core_arbiter;
  localparam int unsigned W   = 64;
  localparam int unsigned TMO = 15;
  localparam int unsigned TW  = 4;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         req0, op0, req1, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, err, busy, core_end;
  logic [W-1:0] rsp, core_a, core_b, core_mm, core_as;
  logic [2:0]   core_sel;

  int checks = 0;
  int errors = 0;

  // Behavioural core
  logic [7:0]   cc;
  int unsigned  core_n;
  logic         core_stuck;
  // Model: rr pointer state
  logic         model_ptr;

  always #5 clk = ~clk;

  fp_core_arbiter #(.W(W), .TMO(TMO), .TW(TW)) dut (
    .clk(clk), .rst_b(rst_b),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .rsp(rsp), .err(err), .busy(busy),
    .core_sel(core_sel), .core_a(core_a), .core_b(core_b),
    .core_mm(core_mm), .core_end(core_end), .core_as(core_as)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                 cc <= '0;
    else if (core_sel == 3'b100) cc <= cc + 8'd1;
    else                        cc <= '0;
  end
  assign core_end = !core_stuck && (core_sel == 3'b100) && (32'(cc) >= core_n);
  assign core_mm  = core_a ^ core_b;
  assign core_as  = core_a - core_b;

  // ack0/ack1 never together, err only alongside an ack
  always @(negedge clk) begin
    checks++;
    if ((ack0 && ack1) || (err && !(ack0 || ack1))) begin
      errors++;
      $display("FAIL pulse_excl: ack0=%b ack1=%b err=%b required exclusive acks, err only with ack", ack0, ack1, err);
    end
  end

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [W-1:0] model_res(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (op) r = a ^ b;
    else    r = a - b;
    return r;
  endfunction

  // Edges from driving a request (before the sample edge) to the ack being visible
  function automatic int model_lat(input logic op, input int unsigned n);
    if (!op)     return 2;
    if (n > TMO) return int'(TMO) + 2;
    return int'(n) + 2;
  endfunction

  task automatic wait_ack(input int limit, output int lat, output logic who,
                          output logic [W-1:0] r, output logic e);
    logic seen = 1'b0;
    lat = 0; who = 1'b0; r = '0; e = 1'b0;
    while (!seen && lat < limit) begin
      @(posedge clk); #1;
      lat++;
      if (ack0 || ack1) begin
        seen = 1'b1; who = ack1; r = rsp; e = err;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout: no ack within %0d cycles, required an ack", limit);
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    model_ptr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ack0, ack1, err, busy} !== 4'b0 || rsp !== '0 || core_sel !== 3'b000 ||
        core_a !== '0 || core_b !== '0) begin
      errors++;
      $display("FAIL reset_state: ack0=%b ack1=%b err=%b busy=%b rsp=%h sel=%b a=%h b=%h required all zero",
               ack0, ack1, err, busy, rsp, core_sel, core_a, core_b);
    end
    do_reset();
  endtask

  task automatic test_mult_single();
    int lat; logic who, e; logic [W-1:0] r;
    core_n = 6;
    req0 = 1; op0 = 1; a0 = 64'd5; b0 = 64'd3;
    wait_ack(60, lat, who, r, e);
    req0 = 0;
    model_ptr = 1'b1;
    checks++;
    if (who !== 1'b0 || r !== 64'd6 || e !== 1'b0 || lat != model_lat(1'b1, 6)) begin
      errors++;
      $display("FAIL mult_single: who=%b rsp=%0d err=%b lat=%0d required who=0 rsp=6 err=0 lat=%0d",
               who, r, e, lat, model_lat(1'b1, 6));
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack0 || ack1) begin
        errors++;
        $display("FAIL mult_single_extra: ack0=%b ack1=%b required 0 after completion", ack0, ack1);
      end
    end
  endtask

  task automatic test_addsub();
    req1 = 1; op1 = 0; a1 = 64'd10; b1 = 64'd4;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || core_sel !== 3'b010 || core_a !== 64'd10 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL addsub_issue: busy=%b sel=%b core_a=%0d ack1=%b required busy=1 sel=010 core_a=10 ack1=0",
               busy, core_sel, core_a, ack1);
    end
    @(posedge clk); #1;
    req1 = 0;
    model_ptr = 1'b0;
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || rsp !== 64'd6 || err !== 1'b0 || busy !== 1'b0 || core_sel !== 3'b000) begin
      errors++;
      $display("FAIL addsub_ack: ack1=%b ack0=%b rsp=%0d err=%b busy=%b sel=%b required ack1=1 rsp=6 err=0 busy=0 sel=000",
               ack1, ack0, rsp, err, busy, core_sel);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_both_mult();
    int lat; logic who, e; logic [W-1:0] r;
    do_reset();
    core_n = 3;
    req0 = 1; op0 = 1; a0 = rnd(); b0 = rnd();
    req1 = 1; op1 = 1; a1 = rnd(); b1 = rnd();
    wait_ack(40, lat, who, r, e);
    req0 = 0;
    checks++;
    if (who !== 1'b0 || r !== (a0 ^ b0) || e !== 1'b0 || core_sel !== 3'b000) begin
      errors++;
      $display("FAIL both_first: who=%b rsp=%h err=%b sel=%b required who=0 rsp=%h err=0 sel=000",
               who, r, e, core_sel, a0 ^ b0);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || core_sel !== 3'b000 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL both_drain: busy=%b sel=%b ack1=%b required idle gap with sel=000", busy, core_sel, ack1);
    end
    wait_ack(40, lat, who, r, e);
    req1 = 0;
    model_ptr = 1'b0;
    checks++;
    if (who !== 1'b1 || r !== (a1 ^ b1) || e !== 1'b0 || lat != model_lat(1'b1, 3)) begin
      errors++;
      $display("FAIL both_second: who=%b rsp=%h err=%b lat=%0d required who=1 rsp=%h err=0 lat=%0d",
               who, r, e, lat, a1 ^ b1, model_lat(1'b1, 3));
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    int lat; logic who, e; logic [W-1:0] r, ea, exp_r;
    req0 = 1; op0 = 1'($urandom()); a0 = rnd(); b0 = rnd();
    req1 = 1; op1 = 1'($urandom()); a1 = rnd(); b1 = rnd();
    core_n = $urandom_range(1, 10);
    for (int i = 0; i < 6; i++) begin
      exp_r = model_ptr ? model_res(op1, a1, b1) : model_res(op0, a0, b0);
      ea    = model_ptr ? a1 : a0;
      wait_ack(40, lat, who, r, e);
      checks++;
      if (who !== model_ptr || r !== exp_r || e !== 1'b0 || core_a !== ea) begin
        errors++;
        $display("FAIL fairness[%0d]: who=%b rsp=%h err=%b core_a=%h required who=%b rsp=%h err=0 core_a=%h",
                 i, who, r, e, core_a, model_ptr, exp_r, ea);
      end
      if (model_ptr) begin op1 = 1'($urandom()); a1 = rnd(); b1 = rnd(); end
      else           begin op0 = 1'($urandom()); a0 = rnd(); b0 = rnd(); end
      core_n = $urandom_range(1, 10);
      model_ptr = ~model_ptr;
    end
    req0 = 0; req1 = 0;
    repeat (3) @(posedge clk); #1;
    // Both requesters were held, so the last grant may have been issued on the final ack cycle
    while (busy) begin
      @(posedge clk); #1;
    end
    if (ack0 || ack1) model_ptr = ~model_ptr;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int lat; logic who, e; logic [W-1:0] r;
    do_reset();
    core_stuck = 1'b1;
    req0 = 1; op0 = 1; a0 = rnd(); b0 = rnd();
    wait_ack(60, lat, who, r, e);
    req0 = 0;
    model_ptr = 1'b1;
    checks++;
    if (who !== 1'b0 || e !== 1'b1 || r !== '0 || lat != model_lat(1'b1, TMO + 1)) begin
      errors++;
      $display("FAIL timeout: who=%b err=%b rsp=%h lat=%0d required who=0 err=1 rsp=0 lat=%0d",
               who, e, r, lat, model_lat(1'b1, TMO + 1));
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || ack0 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b err=%b ack0=%b required 0", busy, err, ack0);
    end
    core_stuck = 1'b0;
    core_n = TMO;
    req0 = 1; op0 = 1; a0 = rnd(); b0 = rnd();
    wait_ack(60, lat, who, r, e);
    req0 = 0;
    model_ptr = 1'b1;
    checks++;
    if (who !== 1'b0 || e !== 1'b0 || r !== (a0 ^ b0) || lat != model_lat(1'b1, TMO)) begin
      errors++;
      $display("FAIL end_vs_timeout: who=%b err=%b rsp=%h lat=%0d required who=0 err=0 rsp=%h lat=%0d",
               who, e, r, lat, a0 ^ b0, model_lat(1'b1, TMO));
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic who, e, first, p0, p1, fop; logic [W-1:0] r, exp_r;
    for (int it = 0; it < 12; it++) begin
      p0 = 1'($urandom()); p1 = 1'($urandom());
      if (!p0 && !p1) p0 = 1'b1;
      core_n = $urandom_range(1, 10);
      op0 = 1'($urandom()); a0 = rnd(); b0 = rnd();
      op1 = 1'($urandom()); a1 = rnd(); b1 = rnd();
      req0 = p0; req1 = p1;
      first = (p0 && p1) ? model_ptr : p1;
      for (int k = 0; k < 2; k++) begin
        if (k == 1 && !(p0 && p1)) break;
        exp_r = first ? model_res(op1, a1, b1) : model_res(op0, a0, b0);
        fop   = first ? op1 : op0;
        wait_ack(40, lat, who, r, e);
        checks++;
        if (who !== first || r !== exp_r || e !== 1'b0 || (k == 0 && lat != model_lat(fop, core_n))) begin
          errors++;
          $display("FAIL random[%0d.%0d]: who=%b rsp=%h err=%b lat=%0d required who=%b rsp=%h err=0 lat=%0d",
                   it, k, who, r, e, lat, first, exp_r, model_lat(fop, core_n));
        end
        if (first) req1 = 0; else req0 = 0;
        model_ptr = ~first;
        first = ~first;
      end
      repeat (2) @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic who, e; logic [W-1:0] r;
    core_stuck = 1'b1;
    req0 = 1; op0 = 1; a0 = rnd(); b0 = rnd();
    repeat (4) @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({ack0, ack1, err, busy} !== 4'b0 || rsp !== '0 || core_sel !== 3'b000 ||
        core_a !== '0 || core_b !== '0) begin
      errors++;
      $display("FAIL reset_midop: ack0=%b ack1=%b err=%b busy=%b rsp=%h sel=%b required all zero",
               ack0, ack1, err, busy, rsp, core_sel);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack0 || ack1 || busy) begin
        errors++;
        $display("FAIL reset_hold: ack0=%b ack1=%b busy=%b required 0", ack0, ack1, busy);
      end
    end
    core_stuck = 1'b0;
    core_n = 4;
    @(negedge clk) rst_b = 1'b1;
    model_ptr = 1'b0;
    wait_ack(40, lat, who, r, e);
    req0 = 0;
    checks++;
    if (who !== 1'b0 || e !== 1'b0 || r !== (a0 ^ b0) || lat != model_lat(1'b1, 4)) begin
      errors++;
      $display("FAIL reset_regrant: who=%b err=%b rsp=%h lat=%0d required who=0 err=0 rsp=%h lat=%0d",
               who, e, r, lat, a0 ^ b0, model_lat(1'b1, 4));
    end
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    rst_b = 1'b0;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    core_n = 4; core_stuck = 1'b0; model_ptr = 1'b0;
    test_reset();
    test_mult_single();
    test_addsub();
    test_both_mult();
    test_fairness();
    test_timeout();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
